// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache.
// A hit returns the selected 32-bit word combinationally. A miss stalls the
// CPU through BUSYWAIT while a 16-byte block is fetched from memory.
// Optional build macro ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT
// outputs; without it those ports and counters do not exist.
module instr_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   PC,
    output logic [31:0]   INSTRUCTION,
    output logic          BUSYWAIT,
    output logic          MEM_READ,
    output logic [5:0]    MEM_ADDRESS,
    input  logic [127:0]  MEM_READDATA,
    input  logic          MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]   HIT_COUNT,
    output logic [15:0]   MISS_COUNT
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 6 - INDEX_BITS;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_READ = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    // Fields of the current fetch address
    logic [1:0]            pc_offset;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  unused_pc_bits;

    // Controller state and the block being filled
    logic [1:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] fill_index_q, fill_index_d;
    logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;

    // Line storage
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [TAG_BITS-1:0]   tag_d  [LINES];
    logic [127:0]          data_q [LINES];
    logic [127:0]          data_d [LINES];

    // Lookup results
    logic                  hit;
    logic [127:0]          hit_line;
    logic [31:0]           hit_word;

    assign pc_offset      = PC[3:2];
    assign pc_index       = PC[4+INDEX_BITS-1:4];
    assign pc_tag         = PC[9:4+INDEX_BITS];
    assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

    // Tag compare and word select for the current PC
    always_comb begin
        hit      = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
        hit_line = data_q[pc_index];
        hit_word = hit_line[{pc_offset, 5'b00000} +: 32];
    end

    // CPU- and memory-facing outputs; reset forces the stall low at once
    always_comb begin
        INSTRUCTION = hit ? hit_word : 32'd0;
        MEM_READ    = (state_q == ST_MEM_READ);
        MEM_ADDRESS = MEM_READ ? {fill_tag_q, fill_index_q} : 6'd0;
        BUSYWAIT    = 1'b0;
        case (state_q)
            ST_IDLE:     BUSYWAIT = !hit;
            ST_MEM_READ: BUSYWAIT = 1'b1;
            ST_UPDATE:   BUSYWAIT = 1'b1;
            default:     BUSYWAIT = 1'b0;
        endcase
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    // Miss handling: latch the missing block, wait for memory, then fill the line
    always_comb begin
        state_d      = state_q;
        fill_index_d = fill_index_q;
        fill_tag_d   = fill_tag_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!hit) begin
                    fill_index_d = pc_index;
                    fill_tag_d   = pc_tag;
                    state_d      = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                data_d[fill_index_q]  = MEM_READDATA;
                tag_d[fill_index_q]   = fill_tag_q;
                valid_d[fill_index_q] = 1'b1;
                state_d               = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and valid bits; reset aborts any fill and empties the cache
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data arrays need no reset since valid bits gate every use
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    // Saturating counters of IDLE-cycle hits and of fills started
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == ST_IDLE) begin
            if (hit && (hit_count_q != 16'hFFFF)) begin
                hit_count_d = hit_count_q + 16'd1;
            end
            if (!hit && (miss_count_q != 16'hFFFF)) begin
                miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    // Statistics registers, cleared by reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`endif

endmodule
